buffer_reader: RTL and testbench
================================

# buffer_reader

Consumer-side controller for the `buffer` FIFO: pulls words out through the `consume`/`empty`/`data_out` interface and presents them downstream on a registered valid/ready stream with packet framing. It sits between the `buffer` instance and any downstream stage that may stall. It holds up to two words internally, so `consume` never depends combinationally on downstream `out_ready`. It counts words into fixed-length packets and flags the last word of each.

## Interface
Parameters:
- `bit_width`, 16, data word width; must equal the `bit_width` of the `buffer` instance it drains.
- `pkt_len`, 4, words per packet; legal values are 1 to 2**16-1.
- `cnt_width`, 16, width of the completed-packet counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `enable`  in  1  when 0, no new words are consumed; words already held still drain.
- `buf_empty`  in  1  from buffer `empty`.
- `buf_data`  in  bit_width  from buffer `data_out`; valid in the same cycle `buf_consume` is 1.
- `buf_consume`  out  1  to buffer `consume`.
- `out_valid`  out  1  downstream word valid.
- `out_ready`  in  1  downstream accept.
- `out_data`  out  bit_width  downstream word.
- `out_last`  out  1  marks the last word of a packet; meaningful only while `out_valid`=1.
- `pkt_cnt`  out  cnt_width  number of completed packets; wraps modulo 2**cnt_width.
- `idle`  out  1  high when `occ`=0 and `buf_empty`=1.

## Operation
- **Internal storage**
  - Two-entry holding queue: `head` and `tail` registers.
  - 2-bit occupancy `occ`, range 0..2.
- **Occupancy states:** EMPTY0 (`occ`=0), ONE (`occ`=1), TWO (`occ`=2).
- **Consume rule:** `buf_consume` = `~rst & enable & ~buf_empty & (occ != 2)`.
  - This is a function of registered `occ` and the buffer flag only.
  - It never depends on `out_ready`.
  - It is never asserted while `buf_empty`=1.
- **Capture:** when `buf_consume`=1, `buf_data` is written at the clock edge.
  - It goes into `head` if `head` will be empty after this cycle's pop.
  - Otherwise it goes into `tail`.
- **Pop:** a pop occurs when `out_valid & out_ready`.
  - `head` is replaced by `tail` if `occ`=2.
  - Otherwise `head` is vacated.
- **Occupancy update:** `occ_next` = `occ` + push − pop.
  - Push and pop in the same cycle leave `occ` unchanged.
  - In ONE with push+pop, the new word goes directly into `head`.
- **Outputs:** `out_valid` = (`occ` != 0); `out_data` = `head`.
- **Word counter** `wcnt`, width ceil(log2(pkt_len)), minimum 1 bit:
  - Increments on each pop.
  - On a pop with `wcnt` = `pkt_len`−1: `wcnt` goes to 0 and `pkt_cnt` increments.
  - `out_last` = (`wcnt` == `pkt_len`−1).
  - When `pkt_len`=1, `out_last` is constant 1 and `pkt_cnt` increments on every pop.
- **Enable deassert:** no partial-packet handling; `wcnt` is preserved and the packet resumes when `enable` returns to 1.

## Timing
- **Reset** (synchronous; while `rst`=1 at a rising edge):
  - `occ`=0, `head`=0, `tail`=0, `wcnt`=0, `pkt_cnt`=0.
  - Resulting outputs: `out_valid`=0, `out_data`=0, `out_last`=0 (unless `pkt_len`=1), `idle`=`buf_empty`.
  - `buf_consume` is 0 combinationally during any cycle with `rst`=1.
  - Reset mid-packet discards held words and the partial count; nothing is popped from the buffer in that cycle.
- **Latency:** a word consumed in cycle N is on `out_data` with `out_valid`=1 in cycle N+1 (when `occ` was 0 or becomes ONE).
- **Throughput:** with `out_ready` held at 1 and the buffer non-empty, steady state is ONE with push+pop every cycle, i.e. 1 word/cycle.
- **Stall:** `out_ready`=0 while in ONE → one more word is consumed and the block moves to TWO, then `buf_consume`=0 until a pop.
  - After a pop from TWO, `buf_consume` reasserts in the next cycle (from ONE).
- **Downstream rules:**
  - `out_data`/`out_last` are stable while `out_valid`=1 and `out_ready`=0.
  - `out_valid` never drops without a pop.
- **Buffer empty:** when `buf_empty` rises, no consume occurs that cycle; held words continue to drain normally.
- **Order:** words leave in exactly the order consumed; no loss or duplication across any stall pattern.

## Test plan
- **Reset values:** after reset, drive `buf_empty`=1 → `out_valid`=0, `out_data`=0, `pkt_cnt`=0, `idle`=1, `buf_consume`=0.
- **Streaming:** buffer model holds 8 words 0x0001..0x0008, `pkt_len`=4, `out_ready`=1, `enable`=1.
  - `buf_consume` is high 8 consecutive cycles.
  - Outputs are 0x0001..0x0008 starting one cycle after the first consume, one per cycle.
  - `out_last` on 0x0004 and 0x0008; `pkt_cnt`=2 at the end.
- **Backpressure:** `out_ready`=0 for 5 cycles mid-stream.
  - Exactly 2 words are held (`occ`=2) and `buf_consume`=0 from the second stalled cycle on.
  - `out_data` is held constant throughout the stall.
  - On release, order is intact and consume resumes the cycle after the first pop.
- **Empty and enable:** buffer empties after 3 words, then refills; separately, `enable`=0 for 4 cycles mid-packet.
  - No consume while `buf_empty`=1 or `enable`=0.
  - `wcnt` resumes and `out_last` lands on the 4th word overall.
- **Reset mid-packet:** assert `rst` for 1 cycle with `occ`=2 and `wcnt`=2.
  - Next cycle: `out_valid`=0, `pkt_cnt`=0, no `buf_consume` during the reset cycle.
  - The first subsequent word carries `out_last`=0 with `wcnt` restarted from 0.
- **Random stress:** `pkt_len`=1 with random `out_ready`/`buf_empty` over 1000 cycles.
  - Scoreboard shows no loss or duplication.
  - `out_last`=1 on every word; `pkt_cnt` equals the pop count modulo 2**16.

Source files
------------

// File: rtl/buffer_reader.sv
// ==== buffer_reader : drains the buffer FIFO into a framed valid/ready stream ====
// ==== rev 1.0 =====================================================================
`default_nettype none

module buffer_reader #(
  parameter int bit_width = 16,
  parameter int pkt_len   = 4,
  parameter int cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 buf_empty,
  input  logic [bit_width-1:0] buf_data,
  output logic                 buf_consume,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [bit_width-1:0] out_data,
  output logic                 out_last,
  output logic [cnt_width-1:0] pkt_cnt,
  output logic                 idle
);

  localparam int WCNT_W = (pkt_len > 1) ? $clog2(pkt_len) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(pkt_len - 1);

  typedef enum logic [1:0] {
    EMPTY0 = 2'd0,
    ONE    = 2'd1,
    TWO    = 2'd2
  } occ_t;

  occ_t                 occ, occ_next;
  logic [bit_width-1:0] head, tail, head_next, tail_next;
  logic [WCNT_W-1:0]    wcnt;
  logic                 push, pop;

  // Consume looks only at registered occupancy, so out_ready never reaches the buffer.
  assign buf_consume = ~rst & enable & ~buf_empty & (occ != TWO);
  assign push        = buf_consume;
  assign out_valid   = (occ != EMPTY0);
  assign pop         = out_valid & out_ready;
  assign out_data    = head;
  assign out_last    = (wcnt == WCNT_LAST);
  assign idle        = (occ == EMPTY0) & buf_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ  <= EMPTY0;
      head <= '0;
      tail <= '0;
    end else begin
      occ  <= occ_next;
      head <= head_next;
      tail <= tail_next;
    end
  end

  always_comb begin
    occ_next  = occ;
    head_next = head;
    tail_next = tail;
    case (occ)
      EMPTY0: begin
        if (push) begin
          head_next = buf_data;
          occ_next  = ONE;
        end
      end
      ONE: begin
        // With push and pop together the head slot frees up, so the new word lands there.
        case ({push, pop})
          2'b10: begin
            tail_next = buf_data;
            occ_next  = TWO;
          end
          2'b01:   occ_next = EMPTY0;
          2'b11:   head_next = buf_data;
          default: occ_next = ONE;
        endcase
      end
      TWO: begin
        if (pop) begin
          head_next = tail;
          occ_next  = ONE;
        end
      end
      default: occ_next = EMPTY0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt    <= '0;
      pkt_cnt <= '0;
    end else if (pop) begin
      if (wcnt == WCNT_LAST) begin
        wcnt    <= '0;
        pkt_cnt <= pkt_cnt + cnt_width'(1);
      end else begin
        wcnt <= wcnt + WCNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_buffer_reader.sv
// ==== tb_buffer_reader : queue-level model plus directed vectors for buffer_reader ====
// ==== rev 1.0 ========================================================================
`default_nettype none

module tb_buffer_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        buf_empty = 1'b1;
  logic [15:0] buf_data = 16'h0;
  logic        out_ready = 1'b0;

  logic        cons_a, valid_a, last_a, idle_a;
  logic [15:0] data_a, pkt_a;
  logic        cons_b, valid_b, last_b, idle_b;
  logic [15:0] data_b, pkt_b;

  int checks = 0;
  int errors = 0;

  logic [15:0] bufq[$];
  logic [15:0] held[$];
  int          pops = 0;
  bit          model_on = 1'b0;

  always #5 clk = ~clk;

  buffer_reader #(.bit_width(16), .pkt_len(4), .cnt_width(16)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .buf_empty(buf_empty), .buf_data(buf_data),
    .buf_consume(cons_a), .out_valid(valid_a), .out_ready(out_ready), .out_data(data_a),
    .out_last(last_a), .pkt_cnt(pkt_a), .idle(idle_a)
  );

  buffer_reader #(.bit_width(16), .pkt_len(1), .cnt_width(16)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .buf_empty(buf_empty), .buf_data(buf_data),
    .buf_consume(cons_b), .out_valid(valid_b), .out_ready(out_ready), .out_data(data_b),
    .out_last(last_b), .pkt_cnt(pkt_b), .idle(idle_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the held words are a plain queue; framing follows from the running pop count.
  always begin : model
    bit          exp_cons, s_rst, s_pop, s_push, s_bufpop;
    logic [15:0] s_word;
    @(negedge clk);
    #2;
    exp_cons = !rst && enable && !buf_empty && (held.size() < 2);
    if (model_on) begin
      chk("consume_a", cons_a, exp_cons);
      chk("consume_b", cons_b, exp_cons);
      chk("valid_a", valid_a, held.size() != 0);
      chk("valid_b", valid_b, held.size() != 0);
      if (held.size() != 0) begin
        chk("data_a", data_a, held[0]);
        chk("data_b", data_b, held[0]);
        chk("last_a", last_a, (pops % 4) == 3);
        chk("last_b", last_b, 1);
      end
      chk("pkt_cnt_a", pkt_a, (pops / 4) % 65536);
      chk("pkt_cnt_b", pkt_b, pops % 65536);
      chk("idle_a", idle_a, (held.size() == 0) && buf_empty);
      chk("idle_b", idle_b, (held.size() == 0) && buf_empty);
    end
    s_rst    = rst;
    s_pop    = (held.size() != 0) && out_ready;
    s_push   = exp_cons;
    s_word   = buf_data;
    s_bufpop = cons_a;
    @(posedge clk);
    if (s_bufpop && bufq.size() != 0) void'(bufq.pop_front());
    if (s_rst) begin
      held.delete();
      pops     = 0;
      model_on = 1'b1;
    end else if (model_on) begin
      if (s_pop) begin
        void'(held.pop_front());
        pops++;
      end
      if (s_push) held.push_back(s_word);
    end
  end

  task automatic tick(input bit r, input bit en, input bit rdy, input bit force_empty);
    @(negedge clk);
    rst       = r;
    enable    = en;
    out_ready = rdy;
    buf_empty = force_empty || (bufq.size() == 0);
    buf_data  = (bufq.size() != 0) ? bufq[0] : 16'h0;
    #3;
  endtask

  initial begin
    logic [15:0] next_word;
    bit          rdy, fe, en;

    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(0, 1, 1, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_data", data_a, 0);
    chk("rst_pkt", pkt_a, 0);
    chk("rst_idle", idle_a, 1);
    chk("rst_consume", cons_a, 0);
    chk("rst_last_a", last_a, 0);
    chk("rst_last_b", last_b, 1);

    // Streaming: 8 words straight through.
    for (int w = 1; w <= 8; w++) bufq.push_back(16'(w));
    for (int i = 0; i <= 10; i++) begin
      tick(0, 1, 1, 0);
      chk("stream_cons", cons_a, i < 8);
      chk("stream_valid", valid_a, (i >= 1) && (i <= 8));
      if (i >= 1 && i <= 8) begin
        chk("stream_data", data_a, i);
        chk("stream_last", last_a, (i == 4) || (i == 8));
      end
    end
    chk("stream_pkt", pkt_a, 2);

    // Backpressure: 5 stalled cycles with 16 words available.
    for (int w = 0; w < 16; w++) bufq.push_back(16'h11 + 16'(w));
    for (int i = 0; i <= 22; i++) begin
      tick(0, 1, !(i >= 3 && i <= 7), 0);
      if (i >= 4 && i <= 8) chk("bp_cons_off", cons_a, 0);
      if (i == 3 || i == 9) chk("bp_cons_on", cons_a, 1);
      if (i >= 3 && i <= 8) chk("bp_hold", data_a, 16'h13);
      if (i == 9) chk("bp_next", data_a, 16'h14);
    end
    tick(0, 1, 1, 0);
    chk("bp_pkt_a", pkt_a, 6);
    chk("bp_pkt_b", pkt_b, 24);

    // Buffer runs dry after 3 words, then refills; last lands on the 4th word.
    for (int w = 0; w < 3; w++) bufq.push_back(16'h31 + 16'(w));
    for (int i = 0; i < 16; i++) begin
      if (i == 8) for (int w = 3; w < 8; w++) bufq.push_back(16'h31 + 16'(w));
      tick(0, 1, 1, 0);
      if (buf_empty) chk("empty_no_cons", cons_a, 0);
      if (valid_a && data_a == 16'h34) chk("empty_last4", last_a, 1);
      if (valid_a && data_a == 16'h33) chk("empty_last3", last_a, 0);
    end
    chk("empty_pkt", pkt_a, 8);

    // Enable dropped for 4 cycles mid-packet.
    for (int w = 0; w < 8; w++) bufq.push_back(16'h51 + 16'(w));
    for (int i = 0; i < 16; i++) begin
      en = !(i >= 2 && i <= 5);
      tick(0, en, 1, 0);
      if (!en) chk("en_no_cons", cons_a, 0);
      if (valid_a && data_a == 16'h54) chk("en_last4", last_a, 1);
      if (valid_a && data_a == 16'h55) chk("en_first", last_a, 0);
    end
    chk("en_pkt_a", pkt_a, 10);
    chk("en_pkt_b", pkt_b, 40);

    // Reset with two words held and wcnt at 2.
    for (int w = 0; w < 6; w++) bufq.push_back(16'h61 + 16'(w));
    tick(0, 1, 1, 0);
    tick(0, 1, 1, 0);
    tick(0, 1, 1, 0);
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    chk("mid_full_cons", cons_a, 0);
    chk("mid_full_data", data_a, 16'h63);
    tick(1, 1, 0, 0);
    chk("mid_rst_cons", cons_a, 0);
    tick(0, 1, 1, 0);
    chk("mid_after_valid", valid_a, 0);
    chk("mid_after_pkt_a", pkt_a, 0);
    chk("mid_after_pkt_b", pkt_b, 0);
    tick(0, 1, 1, 0);
    chk("mid_first_data", data_a, 16'h65);
    chk("mid_first_last", last_a, 0);
    for (int i = 0; i < 4; i++) tick(0, 1, 1, 0);

    // Random stress on both packet lengths.
    next_word = 16'h1000;
    for (int i = 0; i < 1000; i++) begin
      while (bufq.size() < 3) begin
        bufq.push_back(next_word);
        next_word++;
      end
      rdy = 1'($urandom_range(0, 1));
      fe  = ($urandom_range(0, 3) == 0);
      tick(0, 1, rdy, fe);
    end
    for (int i = 0; i < 4; i++) tick(0, 1, 1, 1);
    chk("stress_drained", valid_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
